// File: rtl/delay_tap_calibrator.sv
// Calibration sweep for the 8-tap delay line: step taps 0..7, settle, majority-sample,
// lock on the first tap that reads mostly high. man_en forces the tap and aborts a sweep.
module delay_tap_calibrator #(
   parameter int SETTLE_CYCLES = 4,
   parameter int SAMPLES       = 8,
   parameter int THRESH        = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       sample_in,
   input  logic       man_en,
   input  logic [2:0] man_sel,
   output logic [2:0] sel,
   output logic       busy,
   output logic       done,
   output logic       locked,
   output logic       fail,
   output logic [2:0] tap
);
   localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int ONES_W  = $clog2(SAMPLES + 1);
   localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLES - 1);
   localparam logic [ONES_W-1:0] ONES_MAX    = ONES_W'(SAMPLES);
   localparam logic [ONES_W-1:0] ONES_THR    = ONES_W'(THRESH);

   typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_MEASURE, S_EVAL, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ONES_W-1:0] ones_q, ones_d;
   logic [2:0]        cal_sel_q, cal_sel_d;
   logic [2:0]        tap_q, tap_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              locked_q, locked_d;
   logic              fail_q, fail_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ones_d    = ones_q;
      cal_sel_d = cal_sel_q;
      tap_d     = tap_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      locked_d  = locked_q;
      fail_d    = fail_q;
      // Manual override drops any sweep in flight, including the DONE cycle.
      if (man_en && state_q != S_IDLE) begin
         state_d   = S_IDLE;
         cnt_d     = '0;
         ones_d    = '0;
         cal_sel_d = 3'd0;
         tap_d     = 3'd0;
         busy_d    = 1'b0;
         locked_d  = 1'b0;
         fail_d    = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !man_en) begin
                  state_d   = S_SETTLE;
                  cnt_d     = '0;
                  ones_d    = '0;
                  cal_sel_d = 3'd0;
                  tap_d     = 3'd0;
                  busy_d    = 1'b1;
                  locked_d  = 1'b0;
                  fail_d    = 1'b0;
               end
            end
            S_SETTLE: begin
               if (cnt_q == SETTLE_LAST) begin
                  state_d = S_MEASURE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_MEASURE: begin
               if (sample_in && ones_q != ONES_MAX) ones_d = ones_q + ONES_W'(1);
               if (cnt_q == SAMPLE_LAST) begin
                  state_d = S_EVAL;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_EVAL: begin
               if (ones_q >= ONES_THR) begin
                  state_d  = S_DONE;
                  tap_d    = cal_sel_q;
                  locked_d = 1'b1;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
               end else if (cal_sel_q == 3'd7) begin
                  state_d   = S_DONE;
                  fail_d    = 1'b1;
                  tap_d     = 3'd0;
                  cal_sel_d = 3'd0;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
               end else begin
                  state_d   = S_SETTLE;
                  cal_sel_d = cal_sel_q + 3'd1;
                  cnt_d     = '0;
                  ones_d    = '0;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         ones_q    <= '0;
         cal_sel_q <= 3'd0;
         tap_q     <= 3'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         locked_q  <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ones_q    <= ones_d;
         cal_sel_q <= cal_sel_d;
         tap_q     <= tap_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         locked_q  <= locked_d;
         fail_q    <= fail_d;
      end
   end

   assign sel    = man_en ? man_sel : cal_sel_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign locked = locked_q;
   assign fail   = fail_q;
   assign tap    = tap_q;
endmodule

// File: doc/delay_tap_calibrator.md
# delay_tap_calibrator

Calibration controller for the 8-tap buffer delay line in the ALFSR digitalization path. It drives the 3-bit tap select (s2,s1,s0) and sweeps taps 0..7, letting each tap settle. It then majority-samples the synchronized delay-line output and locks on the first tap whose output is predominantly high. It also offers a manual override so software can force a tap directly.

## Interface
Parameters:
- SETTLE_CYCLES, 4, cycles waited after each tap change before sampling (>=1)
- SAMPLES, 8, sample_in cycles counted per tap (>=1)
- THRESH, 5, minimum number of high samples for a tap to pass (1..SAMPLES)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  level-sampled; begins a sweep when accepted
- sample_in  in  1  delay-line output, already synchronized to clk
- man_en  in  1  manual override enable
- man_sel  in  3  manual tap when man_en=1
- sel  out  3  tap select to delay line, {s2,s1,s0}
- busy  out  1  high while a sweep is running
- done  out  1  one-cycle pulse at sweep end (pass or fail)
- locked  out  1  last sweep found a passing tap
- fail  out  1  last sweep found no passing tap
- tap  out  3  locked tap, 0 if none

## Operation
- States: IDLE, SETTLE, MEASURE, EVAL, DONE.
- IDLE:
  - start=1 and man_en=0 at an edge moves to SETTLE.
  - That same edge clears locked, fail and tap, sets cal_sel=0, busy=1, and zeroes the counters.
- SETTLE: counts SETTLE_CYCLES cycles, then moves to MEASURE.
- MEASURE:
  - Samples sample_in on each of SAMPLES edges.
  - ones counter width is $clog2(SAMPLES+1); it never wraps.
- EVAL (one cycle):
  - If ones >= THRESH: tap=cal_sel, locked=1, go to DONE.
  - Else if cal_sel==7: fail=1, tap=0, cal_sel=0, go to DONE.
  - Else cal_sel+1, clear counters, go to SETTLE.
- DONE (one cycle): done=1, busy=0, then IDLE.
- cal_sel holds the locked tap after a pass and 0 after a fail.
- sel = man_en ? man_sel : cal_sel. This is the only combinational path.
- man_en=1 in any non-IDLE state aborts at the next edge:
  - state goes to IDLE, busy=0.
  - no done pulse; locked=0, fail=0, tap=0, cal_sel=0.
- start while busy is ignored; start held high after DONE starts a new sweep from IDLE.
- start and man_en both high in IDLE: man_en wins, no sweep.

## Timing
- Reset values: sel=0 (given man_en=0), busy=0, done=0, locked=0, fail=0, tap=0, state IDLE.
- rst_n=0 mid-sweep returns everything to reset values at that edge; no done pulse.
- Per-tap cost is SETTLE_CYCLES+SAMPLES+1 cycles; 13 with defaults.
- Lock at tap k, start accepted at edge E0:
  - done high in the cycle following edge E0+(k+1)·(SETTLE_CYCLES+SAMPLES+1).
  - locked, tap and sel are valid from that same cycle.
- Fail: done at E0+8·(SETTLE_CYCLES+SAMPLES+1), i.e. 104 cycles with defaults.
- busy is high from the cycle after E0 through the EVAL cycle inclusive; low in the DONE cycle.
- sel changes only at SETTLE entry, so sample_in is never counted within SETTLE_CYCLES of a tap change.

## Test plan
- Reset: hold rst_n=0 for 2 cycles mid-sweep, with start and man_en low. All outputs read 0 and no done pulse occurs.
- Lock at tap 3 (defaults): sample_in=1 whenever sel>=3, else 0; pulse start.
  - sel steps 0,1,2,3; done pulses at E0+52.
  - Then locked=1, tap=3, sel=3, fail=0.
- Threshold boundary: at tap 0 drive exactly 5 of 8 samples high, which locks tap 0 with done at E0+13. Rerun with 4 of 8 high: tap 0 is rejected and the sweep proceeds to tap 1.
- Fail: sample_in=0 throughout, so fail=1, locked=0, tap=0, sel=0, with done at E0+104.
- Manual abort: man_en=1 with man_sel=6 during MEASURE of tap 2.
  - sel=6 immediately; next cycle busy=0, with no done and locked/fail=0.
  - Dropping man_en returns sel to 0.
- Start ignored: a second start pulse during busy does not change the sweep; timing stays identical to the lock-at-tap-3 case.
